// File: rtl/async_fifo_fwft_lane_reader_if.sv
// -----------------------------------------------------------------------------
// async_fifo_fwft_lane_reader_if
// Bundles the FIFO FWFT read port and the narrow valid/ready output stream
// of async_fifo_fwft_lane_reader.
//   Parameters: W  - FIFO word width in bits
//               LW - output lane width in bits
//   Signals:    fifo_empty, fifo_rd_data[W], fifo_rd_en   (FIFO side)
//               out_valid, out_ready, out_data[LW], out_last (stream side)
//   Modports:   master - the lane reader (pops FIFO, drives stream)
//               slave  - the environment (FIFO + downstream consumer)
// -----------------------------------------------------------------------------
interface async_fifo_fwft_lane_reader_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned LW = 8
);
    logic          fifo_empty;
    logic [W-1:0]  fifo_rd_data;
    logic          fifo_rd_en;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic          out_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/async_fifo_fwft_lane_reader.sv
// -----------------------------------------------------------------------------
// async_fifo_fwft_lane_reader
// Single-clock consumer of an FWFT FIFO read port. Pops one wide word and
// emits it as LANES narrow lanes, LSB lane first, on a valid/ready stream,
// optionally marking packet boundaries with out_last.
//   clk          - clock (FIFO read-clock domain)
//   rst          - synchronous reset, active-high (priority over flush)
//   flush        - synchronous discard of the held word and counters
//   bus          - master modport: fifo_empty/fifo_rd_data/fifo_rd_en and
//                  out_valid/out_ready/out_data/out_last
//   words_read   - words popped, saturating (stats build only, else 0)
//   stall_cycles - cycles with out_valid && !out_ready, saturating
//                  (stats build only, else 0)
// Optional feature macro: ASYNC_FIFO_READER_STATS_EN builds the counters.
// -----------------------------------------------------------------------------
module async_fifo_fwft_lane_reader #(
    parameter int unsigned RD_WIDTH_BYTES   = 4,
    parameter int unsigned WIDTH_RATIO_LOG2 = 2,
    parameter int unsigned PKT_BEATS        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    async_fifo_fwft_lane_reader_if.master        bus,
    output logic [31:0]                          words_read,
    output logic [31:0]                          stall_cycles
);
    localparam int unsigned W     = RD_WIDTH_BYTES * 8;
    localparam int unsigned LANES = 1 << WIDTH_RATIO_LOG2;
    localparam int unsigned LW    = W / LANES;
    localparam int unsigned LIW   = (WIDTH_RATIO_LOG2 > 0) ? WIDTH_RATIO_LOG2 : 1;
    localparam logic [31:0] PKT_LAST = 32'(PKT_BEATS) - 32'd1;

    logic [W-1:0]   hold_data_q,  hold_data_d;
    logic           hold_valid_q, hold_valid_d;
    logic [LIW-1:0] lane_idx_q,   lane_idx_d;
    logic [31:0]    beat_cnt_q,   beat_cnt_d;

    logic           last_lane;
    logic           accept;
    logic           rd_en;
    logic [LW-1:0]  cur_lane;

    // Lane select and last-lane detect collapse to constants for pass-through.
    generate
        if (WIDTH_RATIO_LOG2 == 0) begin : g_single_lane
            assign cur_lane  = hold_data_q;
            assign last_lane = 1'b1;
        end else begin : g_multi_lane
            logic [LANES-1:0][LW-1:0] lanes;
            assign lanes     = hold_data_q;
            assign cur_lane  = lanes[lane_idx_q];
            assign last_lane = (lane_idx_q == LIW'(LANES - 1));
        end
    endgenerate

    assign accept = hold_valid_q && bus.out_ready;

    // Reload on the same edge that retires the last lane keeps the stream
    // bubble-free across word boundaries.
    assign rd_en = !rst && !flush && !bus.fifo_empty &&
                   (!hold_valid_q || (bus.out_ready && last_lane));

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        lane_idx_d   = lane_idx_q;
        beat_cnt_d   = beat_cnt_q;

        if (rd_en) begin
            hold_data_d  = bus.fifo_rd_data;
            hold_valid_d = 1'b1;
            lane_idx_d   = '0;
        end else if (accept) begin
            if (last_lane) begin
                lane_idx_d   = '0;
                hold_valid_d = 1'b0;
            end else begin
                lane_idx_d   = lane_idx_q + LIW'(1);
            end
        end

        if (accept && (PKT_BEATS != 0)) begin
            if (beat_cnt_q == PKT_LAST) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 32'd1;
            end
        end

        // flush wins over any simultaneous load or accept.
        if (flush) begin
            hold_valid_d = 1'b0;
            lane_idx_d   = '0;
            beat_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            lane_idx_q   <= '0;
            beat_cnt_q   <= '0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            lane_idx_q   <= lane_idx_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Outputs are forced low while rst is high so they read 0 during reset,
    // not only after the reset edge.
    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = hold_valid_q && !rst;
    assign bus.out_data   = rst ? '0 : cur_lane;
    assign bus.out_last   = (PKT_BEATS != 0) && hold_valid_q && !rst &&
                            (beat_cnt_q == PKT_LAST);

`ifdef ASYNC_FIFO_READER_STATS_EN
    logic [31:0] words_q, words_d;
    logic [31:0] stalls_q, stalls_d;

    always_comb begin
        words_d  = words_q;
        stalls_d = stalls_q;
        if (rd_en && (words_q != '1)) begin
            words_d = words_q + 32'd1;
        end
        if (hold_valid_q && !bus.out_ready && (stalls_q != '1)) begin
            stalls_d = stalls_q + 32'd1;
        end
        if (flush) begin
            words_d  = '0;
            stalls_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q  <= '0;
            stalls_q <= '0;
        end else begin
            words_q  <= words_d;
            stalls_q <= stalls_d;
        end
    end

    assign words_read   = rst ? '0 : words_q;
    assign stall_cycles = rst ? '0 : stalls_q;
`else
    assign words_read   = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_async_fifo_fwft_lane_reader.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_fwft_lane_reader
// Drives async_fifo_fwft_lane_reader from a queue-based FIFO model and checks
// every cycle against a lane-queue reference model of the stream.
// -----------------------------------------------------------------------------
module tb_async_fifo_fwft_lane_reader;
    localparam int unsigned RDB   = 4;
    localparam int unsigned R     = 2;
    localparam int unsigned PKT   = 6;
    localparam int unsigned W     = RDB * 8;
    localparam int unsigned LANES = 1 << R;
    localparam int unsigned LW    = W / LANES;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] words_read;
    logic [31:0] stall_cycles;

    async_fifo_fwft_lane_reader_if #(.W(W), .LW(LW)) bus ();

    async_fifo_fwft_lane_reader #(
        .RD_WIDTH_BYTES  (RDB),
        .WIDTH_RATIO_LOG2(R),
        .PKT_BEATS       (PKT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus.master),
        .words_read  (words_read),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, remaining lanes of the held word,
    // packet beat position and statistics.
    logic [W-1:0]  fq[$];
    logic [LW-1:0] lq[$];
    int unsigned   bc     = 0;
    logic [31:0]   m_words  = '0;
    logic [31:0]   m_stalls = '0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic step(input bit r, input bit f, input bit rdy);
        int unsigned pend;
        bit          exp_rd;
        bit          exp_vld;
        logic [W-1:0] w;
        @(negedge clk);
        rst           = r;
        flush         = f;
        bus.out_ready = rdy;
        bus.fifo_empty   = (fq.size() == 0);
        bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : W'($urandom);
        #1;
        pend    = lq.size();
        exp_rd  = !r && !f && (fq.size() != 0) && (pend == 0 || (rdy && pend == 1));
        exp_vld = !r && (pend != 0);
        check("rd_en", 64'(bus.fifo_rd_en), 64'(exp_rd));
        check("valid", 64'(bus.out_valid), 64'(exp_vld));
        if (exp_vld) check("data", 64'(bus.out_data), 64'(lq[0]));
        if (r)       check("data_rst", 64'(bus.out_data), 64'd0);
        check("last", 64'(bus.out_last), 64'(exp_vld && (bc == PKT - 1)));
`ifdef ASYNC_FIFO_READER_STATS_EN
        check("words", 64'(words_read), r ? 64'd0 : 64'(m_words));
        check("stalls", 64'(stall_cycles), r ? 64'd0 : 64'(m_stalls));
`else
        check("words", 64'(words_read), 64'd0);
        check("stalls", 64'(stall_cycles), 64'd0);
`endif
        // Advance the model to what the next clock edge should produce.
        if (r || f) begin
            lq.delete();
            bc       = 0;
            m_words  = '0;
            m_stalls = '0;
        end else begin
            if (pend != 0 && !rdy) m_stalls = sat_inc(m_stalls);
            if (pend != 0 && rdy) begin
                void'(lq.pop_front());
                bc = (bc + 1) % PKT;
            end
            if (exp_rd) begin
                w = fq.pop_front();
                for (int unsigned i = 0; i < LANES; i++) lq.push_back(w[i*LW +: LW]);
                m_words = sat_inc(m_words);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = '0;
        repeat (3) step(1, 0, 0);

        // Two words streamed with ready held high: lanes 00..07 back to back.
        fq.push_back(32'h0302_0100);
        fq.push_back(32'h0706_0504);
        repeat (10) step(0, 0, 1);

        // Stall on lane 2 of DDCCBBAA.
        fq.push_back(32'hDDCC_BBAA);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        repeat (3) step(0, 0, 1);
        check("stall_cnt_directed",
`ifdef ASYNC_FIFO_READER_STATS_EN
              64'(stall_cycles), 64'd2);
`else
              64'(stall_cycles), 64'd0);
`endif

        // Flush after lane 1 of 44332211; next word starts at lane 0.
        fq.push_back(32'h4433_2211);
        fq.push_back(32'h8877_6655);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        repeat (6) step(0, 0, 1);

        // Reset mid-word with the FIFO empty.
        fq.push_back(32'hCAFE_F00D);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        repeat (3) step(0, 0, 1);

        // Randomized traffic.
        for (int unsigned c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 35 && fq.size() < 8) fq.push_back(W'($urandom));
            step($urandom_range(199) == 0, $urandom_range(49) == 0, $urandom_range(99) < 70);
        end
        // Drain.
        for (int unsigned c = 0; c < 60; c++) step(0, 0, 1);
        check("drained_fifo", 64'(fq.size()), 64'd0);
        check("drained_lanes", 64'(lq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
